// File: rtl/fb_loader_4k_pkg.sv
`default_nettype none
// ============================================================================
// Package : led_panel_pkg
// Purpose : Shared geometry, pixel width, lane masks and the loader state
//           enumeration for the 64x64 12bpp LED panel feeder.
// Rev     : 1.0  initial release
// ============================================================================
package led_panel_pkg;

  localparam int NUM_COLS  = 64;
  localparam int NUM_ROWS  = 64;
  localparam int BIT_DEPTH = 4;

  localparam int PW        = 3 * BIT_DEPTH;
  localparam int ADDR_W    = $clog2(NUM_COLS * NUM_ROWS / 2);
  localparam int PIX_IDX_W = $clog2(NUM_COLS * NUM_ROWS);

  localparam logic [PIX_IDX_W-1:0] LAST_PIX = PIX_IDX_W'(NUM_COLS * NUM_ROWS - 1);

  // Lane enables for the {top, bottom} half-screen memory word
  localparam logic [1:0] LANE_TOP = 2'b10;
  localparam logic [1:0] LANE_BOT = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B0   = 3'd1,
    ST_B1   = 3'd2,
    ST_B2   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fb_loader_4k_if.sv
`default_nettype none
// ============================================================================
// Interface : fb_loader_4k_if
// Purpose   : Byte-stream input handshake plus frame-memory write port of
//             the frame loader. slave = loader side, master = host/memory side.
// Rev       : 1.0  initial release
// ============================================================================
interface fb_loader_4k_if;
  import led_panel_pkg::*;

  logic              frame_start;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2*PW-1:0]   wr_data;
  logic [1:0]        wr_mask;
  logic              busy;
  logic              frame_done;

  modport slave (
    input  frame_start, in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, wr_mask, busy, frame_done
  );

  modport master (
    output frame_start, in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, wr_mask, busy, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/fb_loader_4k_px_unpack_12.sv
`default_nettype none
// ============================================================================
// Module  : px_unpack_12
// Purpose : 3-byte to 2-pixel unpacker. Holds the partial-byte registers and
//           assembles a 12-bit pixel on the byte that completes it. The byte
//           phase (B0/B1/B2) is the frame FSM's state, passed in.
// Rev     : 1.0  initial release
// ============================================================================
module px_unpack_12
  import led_panel_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  state_t        state_i,      // current byte phase
  input  logic          clear_i,      // frame (re)start: drop partial bytes
  input  logic [7:0]    byte_i,
  input  logic          fire_i,       // byte transfer this cycle (already gated)
  output logic [PW-1:0] pix_o,
  output logic          pix_valid_o
);

  logic [7:0] hi_q, hi_d;   // p0[11:4]
  logic [3:0] lo_q, lo_d;   // p1[11:8]

  // Pixel assembly and partial-byte capture for the current phase
  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    pix_o       = '0;
    pix_valid_o = 1'b0;
    if (clear_i) begin
      hi_d = '0;
      lo_d = '0;
    end else if (fire_i) begin
      case (state_i)
        ST_B0: hi_d = byte_i;
        ST_B1: begin
          pix_o       = {hi_q, byte_i[7:4]};
          pix_valid_o = 1'b1;
          lo_d        = byte_i[3:0];
        end
        ST_B2: begin
          pix_o       = {lo_q, byte_i};
          pix_valid_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Partial-byte registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_loader_4k.sv
`default_nettype none
// ============================================================================
// Module  : fb_loader_4k
// Purpose : Frame loader for the 64x64 12bpp panel. Unpacks the host byte
//           stream into pixels and writes each one into its lane of the
//           half-screen frame memory, with registered write outputs.
// Rev     : 1.0  initial release
// ============================================================================
module fb_loader_4k
  import led_panel_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  fb_loader_4k_if.slave  bus
);

  state_t                 state_q, state_d;
  logic [PIX_IDX_W-1:0]   idx_q, idx_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [2*PW-1:0]        wr_data_q, wr_data_d;
  logic [1:0]             wr_mask_q, wr_mask_d;
  logic                   frame_done_q, frame_done_d;

  logic                   loading;
  logic                   byte_fire;
  logic [PW-1:0]          pix;
  logic                   pix_valid;

  assign loading   = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2);
  // A byte arriving together with frame_start belongs to the aborted frame
  assign byte_fire = bus.in_valid && loading && !bus.frame_start;

  assign bus.in_ready   = loading;
  assign bus.busy       = loading;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_mask    = wr_mask_q;
  assign bus.frame_done = frame_done_q;

  px_unpack_12 u_unpack (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_i     (state_q),
    .clear_i     (bus.frame_start),
    .byte_i      (bus.in_data),
    .fire_i      (byte_fire),
    .pix_o       (pix),
    .pix_valid_o (pix_valid)
  );

  // Next state, pixel index and write-port contents
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_mask_d    = wr_mask_q;
    frame_done_d = 1'b0;

    if (pix_valid) begin
      wr_en_d      = 1'b1;
      // row[4:0],col is simply the low index bits; row[5] picks the lane
      wr_addr_d    = idx_q[ADDR_W-1:0];
      wr_mask_d    = idx_q[PIX_IDX_W-1] ? LANE_BOT : LANE_TOP;
      wr_data_d    = {pix, pix};
      frame_done_d = (idx_q == LAST_PIX);
      idx_d        = idx_q + PIX_IDX_W'(1);
    end

    case (state_q)
      ST_IDLE, ST_DONE: if (bus.frame_start) state_d = ST_B0;
      ST_B0: begin
        if (bus.frame_start)  state_d = ST_B0;
        else if (byte_fire)   state_d = ST_B1;
      end
      ST_B1: begin
        if (bus.frame_start)  state_d = ST_B0;
        else if (byte_fire)   state_d = ST_B2;
      end
      ST_B2: begin
        if (bus.frame_start)  state_d = ST_B0;
        else if (byte_fire)   state_d = (idx_q == LAST_PIX) ? ST_DONE : ST_B0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.frame_start) idx_d = '0;
  end

  // State, index and registered write outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_mask_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_mask_q    <= wr_mask_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_loader_4k.sv
`default_nettype none
// ============================================================================
// Module  : tb_fb_loader_4k
// Purpose : Self-checking bench for fb_loader_4k. Random byte frames are
//           compared against a pixel model built from the packing rules.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fb_loader_4k;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fb_loader_4k_if bus ();

  fb_loader_4k dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] addr;
    logic [23:0] data;
    logic [1:0]  mask;
    logic        done;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] fb [6144];
  int         checks = 0;
  int         passed = 0;
  int         done_cnt = 0;
  int         stray_done = 0;
  int         timeouts = 0;

  // Record every memory write and every frame_done pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en === 1'b1)
        wq.push_back('{addr: bus.wr_addr, data: bus.wr_data, mask: bus.wr_mask, done: bus.frame_done});
      if (bus.frame_done === 1'b1) begin
        done_cnt++;
        if (bus.wr_en !== 1'b1) stray_done++;
      end
    end
  end

  // Reference: pixel i of the frame held in fb[]
  function automatic logic [11:0] exp_pix(input int i);
    int k;
    logic [7:0] b0, b1, b2;
    k  = (i / 2) * 3;
    b0 = fb[k];
    b1 = fb[k+1];
    b2 = fb[k+2];
    if (i % 2 == 0) return {b0, b1[7:4]};
    else            return {b1[3:0], b2};
  endfunction

  // Offer one byte until accepted; idle_pct = chance of a bubble cycle
  task automatic send_byte(input logic [7:0] b, input int idle_pct);
    int  n = 0;
    bit  acc = 1'b0;
    bit  got = 1'b0;
    if (timeouts != 0) return;
    while (!got && n < 64) begin
      @(negedge clk);
      if ($urandom_range(99) < idle_pct) begin
        bus.in_valid = 1'b0;
        acc = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        acc = bus.in_ready;
      end
      @(posedge clk);
      if (acc) got = 1'b1;
      n++;
    end
    if (!got) timeouts++;
  endtask

  task automatic pulse_fs(input logic vld, input logic [7:0] d);
    @(negedge clk);
    bus.frame_start = 1'b1;
    bus.in_valid    = vld;
    bus.in_data     = d;
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if ({bus.in_ready, bus.wr_en, bus.busy, bus.frame_done} !== 4'b0)
      $display("FAIL reset_ctrl: got %b want 0000", {bus.in_ready, bus.wr_en, bus.busy, bus.frame_done});
    else passed++;
    checks++; if ({bus.wr_addr, bus.wr_data, bus.wr_mask} !== 37'd0)
      $display("FAIL reset_bus: addr %h data %h mask %b want zeros", bus.wr_addr, bus.wr_data, bus.wr_mask);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0 || wq.size() != 0)
      $display("FAIL idle_no_accept: in_ready %b writes %0d want 0 0", bus.in_ready, wq.size());
    else passed++;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_first_pixels();
    pulse_fs(1'b0, 8'h00);
    checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1)
      $display("FAIL armed: busy %b in_ready %b want 1 1", bus.busy, bus.in_ready);
    else passed++;
    send_byte(8'hAB, 0);
    #1;
    checks++; if (bus.wr_en !== 1'b0)
      $display("FAIL no_write_b0: wr_en %b want 0", bus.wr_en);
    else passed++;
    send_byte(8'hCD, 0);
    #1;
    checks++; if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_mask} !== {1'b1, 11'h000, 24'hABCABC, 2'b10})
      $display("FAIL first_write: en %b addr %h data %h mask %b want 1 000 abcabc 10",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_mask);
    else passed++;
    send_byte(8'hEF, 0);
    #1;
    checks++; if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_mask} !== {1'b1, 11'h001, 24'hDEFDEF, 2'b10})
      $display("FAIL second_write: en %b addr %h data %h mask %b want 1 001 defdef 10",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_mask);
    else passed++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.wr_en !== 1'b0)
      $display("FAIL write_one_cycle: wr_en %b want 0", bus.wr_en);
    else passed++;
  endtask

  task automatic test_full_frame(input int idle_pct);
    int errs = 0;
    logic [11:0] p;
    for (int i = 0; i < 6144; i++) fb[i] = 8'($urandom);
    pulse_fs(1'b0, 8'h00);
    wq.delete();
    done_cnt = 0;
    stray_done = 0;
    for (int i = 0; i < 6144; i++) send_byte(fb[i], idle_pct);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (timeouts != 0)
      $display("FAIL frame_accept_%0d: %0d byte timeouts want 0", idle_pct, timeouts);
    else passed++;
    checks++; if (wq.size() != 4096)
      $display("FAIL frame_write_count_%0d: got %0d want 4096", idle_pct, wq.size());
    else passed++;
    for (int i = 0; i < wq.size() && i < 4096; i++) begin
      p = exp_pix(i);
      if (wq[i].addr !== 11'(i % 2048) || wq[i].data !== {p, p} ||
          wq[i].mask !== ((i < 2048) ? 2'b10 : 2'b01) || wq[i].done !== (i == 4095))
        errs++;
    end
    checks++; if (errs != 0)
      $display("FAIL frame_contents_%0d: %0d bad writes want 0", idle_pct, errs);
    else passed++;
    if (wq.size() > 2048) begin
      checks++; if (wq[2048].addr !== 11'h000 || wq[2048].mask !== 2'b01)
        $display("FAIL pix2048_%0d: addr %h mask %b want 000 01", idle_pct, wq[2048].addr, wq[2048].mask);
      else passed++;
    end
    if (wq.size() >= 4096) begin
      checks++; if (wq[4095].addr !== 11'h7FF || wq[4095].mask !== 2'b01 || wq[4095].done !== 1'b1)
        $display("FAIL pix4095_%0d: addr %h mask %b done %b want 7ff 01 1",
                 idle_pct, wq[4095].addr, wq[4095].mask, wq[4095].done);
      else passed++;
    end
    checks++; if (done_cnt != 1 || stray_done != 0)
      $display("FAIL frame_done_pulse_%0d: pulses %0d stray %0d want 1 0", idle_pct, done_cnt, stray_done);
    else passed++;
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL after_frame_%0d: in_ready %b busy %b want 0 0", idle_pct, bus.in_ready, bus.busy);
    else passed++;
  endtask

  task automatic test_after_done();
    int rdy = 0;
    wq.delete();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(8'h5A + i);
      if (bus.in_ready !== 1'b0) rdy++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (rdy != 0 || wq.size() != 0)
      $display("FAIL done_hold: ready cycles %0d writes %0d want 0 0", rdy, wq.size());
    else passed++;
    pulse_fs(1'b0, 8'h00);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wq.size() != 2 || wq[0].addr !== 11'h000 || wq[0].data !== 24'h112112)
      $display("FAIL restart_write: writes %0d addr %h data %h want 2 000 112112",
               wq.size(), (wq.size() > 0) ? wq[0].addr : 11'h0, (wq.size() > 0) ? wq[0].data : 24'h0);
    else passed++;
  endtask

  task automatic test_abort();
    pulse_fs(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
    // abort while a byte is offered and in_ready is high
    pulse_fs(1'b1, 8'h99);
    wq.delete();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (wq.size() != 2)
      $display("FAIL abort_count: got %0d want 2", wq.size());
    else passed++;
    if (wq.size() == 2) begin
      checks++; if (wq[0].addr !== 11'h000 || wq[0].data !== 24'h123123 || wq[0].mask !== 2'b10)
        $display("FAIL abort_pix0: addr %h data %h mask %b want 000 123123 10", wq[0].addr, wq[0].data, wq[0].mask);
      else passed++;
      checks++; if (wq[1].addr !== 11'h001 || wq[1].data !== 24'h456456 || wq[1].mask !== 2'b10)
        $display("FAIL abort_pix1: addr %h data %h mask %b want 001 456456 10", wq[1].addr, wq[1].data, wq[1].mask);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    int rdy = 0;
    pulse_fs(1'b0, 8'h00);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    #1;
    checks++; if (bus.wr_en !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL pre_reset: wr_en %b busy %b want 1 1", bus.wr_en, bus.busy);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({bus.in_ready, bus.wr_en, bus.busy, bus.frame_done, bus.wr_addr, bus.wr_data, bus.wr_mask} !== 41'd0)
      $display("FAIL async_reset: rdy %b en %b busy %b done %b addr %h data %h mask %b want all 0",
               bus.in_ready, bus.wr_en, bus.busy, bus.frame_done, bus.wr_addr, bus.wr_data, bus.wr_mask);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC3;
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) rdy++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (rdy != 0 || wq.size() != 0)
      $display("FAIL post_reset_idle: busy/ready cycles %0d writes %0d want 0 0", rdy, wq.size());
    else passed++;
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_first_pixels();
    test_full_frame(0);
    test_after_done();
    test_abort();
    test_full_frame(50);
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_loader_4k.md
Name: fb_loader_4k

Overview:
- Upstream feeder for the 64x64 12bpp LED panel driver.
- Accepts a packed byte stream (two 12-bit pixels per 3 bytes) in raster order from the host link (UART/SPI receiver).
- Unpacks the bytes into pixels and writes each pixel into the panel's half-screen frame memory.
- Each memory word is 24 bits and holds {top-half pixel, bottom-half pixel} for one {ROW[4:0], COL} address. The block therefore writes one 12-bit lane per pixel, using a lane mask.

Parameters:
- NUM_COLS, 64, panel columns; power of 2.
- NUM_ROWS, 64, panel rows; power of 2; the two halves are scanned together.
- BIT_DEPTH, 4, bits per colour channel. Pixel width PW = 3*BIT_DEPTH = 12.
- ADDR_W, $clog2(NUM_COLS*NUM_ROWS/2) = 11, frame memory address width.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- frame_start, in, 1, single-cycle pulse that (re)arms loading of a new frame at pixel 0.
- in_data, in, 8, stream byte.
- in_valid, in, 1, in_data is valid.
- in_ready, out, 1, block accepts the byte. A transfer occurs when in_valid and in_ready are both high on a clk edge.
- wr_en, out, 1, frame memory write strobe, one cycle per pixel.
- wr_addr, out, ADDR_W, address {row[4:0], col[5:0]}.
- wr_data, out, 2*PW, {pix, pix}; the pixel is replicated into both lanes.
- wr_mask, out, 2, lane enable: 2'b10 writes upper lane [23:12] (top half, row<32); 2'b01 writes lower lane [11:0] (bottom half).
- busy, out, 1, high while a frame is being loaded.
- frame_done, out, 1, one-cycle pulse after the last pixel (index 4095) is written.

Behaviour:
- Reset (async, rst=0) forces all outputs to 0: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_mask=0, busy=0, frame_done=0. It also clears the pixel index and the partial-byte register, and sets the state to IDLE.
- State machine: IDLE, B0, B1, B2, DONE.
  - IDLE: in_ready=0. frame_start -> B0 with pixel index = 0.
  - B0: in_ready=1. On a transfer, store the byte as hi = p0[11:4] and go to B1.
  - B1: on a transfer, p0 = {hi, in_data[7:4]}; store lo_nib = in_data[3:0]; issue a write of p0; go to B2.
  - B2: on a transfer, p1 = {lo_nib, in_data}; issue a write of p1; go to B0. If the index is at the last pixel, go to DONE instead.
  - DONE: in_ready=0, busy=0, frame_done pulses for exactly one cycle on entry. The machine stays in DONE until frame_start arrives, then goes to B0 with index 0.
- Write timing: outputs are registered. wr_en asserts in the cycle after the completing byte's transfer edge, for exactly 1 cycle. At most one pixel completes per byte, so writes never collide and in_ready never has to drop mid-frame.
- Address mapping: for pixel index idx[11:0], row = idx[11:6] and col = idx[5:0].
  - wr_addr = {row[4:0], col}.
  - wr_mask = row[5] ? 2'b01 : 2'b10.
  - idx increments after each write. No wrap-around inside a frame; reaching 4095 ends the frame.
- frame_done is asserted in the same cycle as the wr_en for pixel 4095's write, and for that one cycle only.
- busy = 1 in states B0, B1 and B2.
- frame_start while busy (mid-frame abort):
  - Any partial byte is discarded and the index is reset to 0; the next state is B0.
  - A write already registered for the current cycle still completes.
  - A byte transferred in the same cycle as frame_start is dropped.
- in_valid low during B0/B1/B2: the block holds its state indefinitely, with no timeout.
- Width rules: the pixel is exactly PW bits, with no sign or arithmetic. The index is $clog2(NUM_COLS*NUM_ROWS) bits wide.

Decomposition:
- Shared package led_panel_pkg holds:
  - NUM_COLS, NUM_ROWS, BIT_DEPTH;
  - derived PW, ADDR_W, PIX_IDX_W;
  - lane mask constants LANE_TOP = 2'b10 and LANE_BOT = 2'b01;
  - the state enumeration.
- One sub-module, px_unpack_12: the 3-byte to 2-pixel unpacker (B0/B1/B2 phase plus byte registers). It outputs pix and pix_valid.
- fb_loader_4k keeps the frame FSM, the index counter, the address/mask generation and the output registers.

Test Plan:
- Reset then frame_start, bytes 0xAB, 0xCD, 0xEF -> first write: wr_addr=0x000, wr_data=0xABCABC, wr_mask=2'b10. Next cycle after 0xEF: wr_addr=0x001, wr_data=0xDEFDEF, wr_mask=2'b10.
- Full frame of 6144 bytes with continuous in_valid -> exactly 4096 writes.
  - Pixel 2048 (byte offset 3072) writes wr_addr=0x000, wr_mask=2'b01.
  - Pixel 4095 writes wr_addr=0x7FF, wr_mask=2'b01, with frame_done=1 in that cycle.
  - After that: in_ready=0, busy=0.
- Bytes presented after DONE with in_valid=1 -> no transfer and no wr_en until frame_start. After frame_start, the next write targets wr_addr=0x000.
- frame_start after 5 bytes (mid-pixel) -> partial byte dropped. The next 3 bytes 0x12, 0x34, 0x56 produce writes 0x123 at addr 0 and 0x456 at addr 1.
- in_valid toggled randomly (50%) over a full frame -> the write sequence is identical to the continuous case, and there is never more than one wr_en per completed pixel.
- Assert rst low during B2 -> all outputs are 0 asynchronously (before the next clk edge). After release the state is IDLE and in_ready=0 until frame_start.
